// File: rtl/referee_rr.sv
// rtl/referee_rr.sv - round-robin referee: NUM_IN source FIFOs to NUM_OUT destination FIFOs via a 2-stage pipeline
// Optional drop counter/sticky error enabled by defining REFEREE_RR_DROP_CNT_EN.
module referee_rr #(
    parameter int LINE_SIZE = 12,
    parameter int NUM_IN    = 4,
    parameter int NUM_OUT   = 4,
    parameter int DEST_W    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_IN-1:0]           empty,
    input  logic [NUM_IN*LINE_SIZE-1:0] data_in,
    input  logic [NUM_OUT-1:0]          almost_full,
    output logic [NUM_IN-1:0]           pop,
    output logic [NUM_OUT-1:0]          push,
    output logic [LINE_SIZE-1:0]        data_out,
    output logic [1:0]                  fsm_state
`ifdef REFEREE_RR_DROP_CNT_EN
    ,
    output logic [7:0]                  drop_cnt,
    output logic                        drop_err
`endif
);

    localparam int IW = $clog2(NUM_IN);

    typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, STALL = 2'd2} state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          rr_ptr, grant_idx, sel_q;
    logic                   any_ready, af_any, can_pop, grant_found, v1;
    logic [LINE_SIZE-1:0]   sel_word;
    logic [DEST_W-1:0]      dest;
    logic                   dest_ok, drop;
    logic [NUM_OUT-1:0]     dest_onehot;

    assign any_ready = |(~empty);
    assign af_any    = |almost_full;
    // Pop is deliberately independent of fsm_state so the first word leaves in the IDLE->ARB cycle.
    assign can_pop   = ~reset & enable & ~af_any & any_ready;

    always_comb begin
        grant_idx   = rr_ptr;
        grant_found = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            if (!grant_found && !empty[(int'(rr_ptr) + k) % NUM_IN]) begin
                grant_found = 1'b1;
                grant_idx   = IW'((int'(rr_ptr) + k) % NUM_IN);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (can_pop && grant_found) pop[grant_idx] = 1'b1;
    end

    assign sel_word = data_in[sel_q*LINE_SIZE +: LINE_SIZE];

    generate
        if (NUM_OUT == 1) begin : g_single_dest
            assign dest = '0;
        end else begin : g_multi_dest
            assign dest = sel_word[LINE_SIZE-1 -: DEST_W];
        end
    endgenerate

    always_comb begin
        dest_ok     = int'(dest) < NUM_OUT;
        dest_onehot = '0;
        for (int o = 0; o < NUM_OUT; o++) dest_onehot[o] = (int'(dest) == o);
    end

    assign drop = v1 & ~dest_ok;

    // Stage 1 captures the grant; stage 2 samples source data the cycle after the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1       <= 1'b0;
            sel_q    <= '0;
            rr_ptr   <= IW'(NUM_IN - 1);
            push     <= '0;
            data_out <= '0;
        end else begin
            v1 <= can_pop;
            if (can_pop) begin
                sel_q  <= grant_idx;
                rr_ptr <= grant_idx;
            end
            push <= (v1 && dest_ok) ? dest_onehot : '0;
            if (v1 && dest_ok) data_out <= sel_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (enable && af_any)                 state_n = STALL;
                else if (enable && any_ready)         state_n = ARB;
            end
            ARB: begin
                if (af_any)                           state_n = STALL;
                else if (!enable || &empty)           state_n = IDLE;
            end
            STALL: begin
                if (!af_any) state_n = (enable && any_ready) ? ARB : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        fsm_state = state;
    end

`ifdef REFEREE_RR_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
            drop_err <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            drop_err <= 1'b1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_referee_rr.sv
// tb/tb_referee_rr.sv - scoreboard bench for referee_rr (4x4 main instance, 4x3 instance for drop handling)
module tb_referee_rr;

    localparam logic [11:0] W0 = 12'h012;  // dest 0
    localparam logic [11:0] W1 = 12'h4A1;  // dest 1
    localparam logic [11:0] W2 = 12'hA5C;  // dest 2
    localparam logic [11:0] W3 = 12'hC33;  // dest 3

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [3:0]  empty, almost_full, pop, push;
    logic [47:0] data_in;
    logic [11:0] data_out;
    logic [1:0]  fsm_state;

    logic        en3;
    logic [3:0]  emp3, pop3;
    logic [2:0]  af3, push3;
    logic [47:0] din3;
    logic [11:0] dout3;
    logic [1:0]  st3;
`ifdef REFEREE_RR_DROP_CNT_EN
    logic [7:0]  drop_cnt, drop_cnt3;
    logic        drop_err, drop_err3;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  push;
        logic [11:0] data;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data_in = {W3, W2, W1, W0};

    referee_rr #(.LINE_SIZE(12), .NUM_IN(4), .NUM_OUT(4), .DEST_W(2)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .empty(empty), .data_in(data_in),
        .almost_full(almost_full), .pop(pop), .push(push), .data_out(data_out),
        .fsm_state(fsm_state)
`ifdef REFEREE_RR_DROP_CNT_EN
        , .drop_cnt(drop_cnt), .drop_err(drop_err)
`endif
    );

    referee_rr #(.LINE_SIZE(12), .NUM_IN(4), .NUM_OUT(3), .DEST_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .enable(en3), .empty(emp3), .data_in(din3),
        .almost_full(af3), .pop(pop3), .push(push3), .data_out(dout3),
        .fsm_state(st3)
`ifdef REFEREE_RR_DROP_CNT_EN
        , .drop_cnt(drop_cnt3), .drop_err(drop_err3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] word_of(input logic [3:0] onehot);
        case (onehot)
            4'b0001: return W0;
            4'b0010: return W1;
            4'b0100: return W2;
            default: return W3;
        endcase
    endfunction

    // One cycle: drive at posedge+2, check at posedge+4, optionally queue the push due 2 cycles later.
    task automatic step(input logic rst, input logic en, input logic [3:0] emp, input logic [3:0] af,
                        input logic [3:0] exp_pop, input logic [1:0] exp_st, input logic sb);
        logic [11:0] w;
        exp_t e;
        reset = rst; enable = en; empty = emp; almost_full = af;
        #2;
        check("pop", pop, exp_pop);
        check("fsm_state", fsm_state, exp_st);
        if (sb && exp_pop != 4'b0) begin
            w      = word_of(exp_pop);
            e.cyc  = cyc + 2;
            e.push = 4'b0001 << w[11:10];
            e.data = w;
            q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (cyc > 1) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_push: got none expected push=%b data=%h at cycle %0d", q[0].push, q[0].data, q[0].cyc);
                void'(q.pop_front());
            end
            if (push !== 4'b0) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_push: got push=%b data=%h expected none (cycle %0d)", push, data_out, cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("push_cycle", cyc, mon_e.cyc);
                    check("push", push, mon_e.push);
                    check("data_out", data_out, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    localparam logic [3:0] RR_SEQ [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                          4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        reset = 1'b1; enable = 1'b0; empty = 4'hF; almost_full = 4'h0;
        en3 = 1'b0; emp3 = 4'hF; af3 = 3'b0; din3 = '0;
        @(posedge clk);
        #2;
        step(1'b1, 1'b0, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0);
        check("reset_push", push, 4'b0);
        check("reset_data_out", data_out, 12'h0);
        step(1'b1, 1'b0, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0);

        // first grant from reset goes to source 0; FSM follows one cycle later
        step(1'b0, 1'b1, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b1);
        step(1'b0, 1'b1, 4'hE, 4'h0, 4'b0001, 2'd0, 1'b1);
        step(1'b0, 1'b1, 4'hF, 4'h0, 4'b0000, 2'd1, 1'b1);
        step(1'b0, 1'b1, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b1);

        q.delete();
        step(1'b1, 1'b0, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 1'b0, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0);

        // all sources busy: full-rate round robin
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 4'h0, 4'h0, RR_SEQ[i], (i == 0) ? 2'd0 : 2'd1, 1'b1);

        // almost_full mid-stream: in-flight words still drain, resume after last grant
        step(1'b0, 1'b1, 4'h0, 4'b0010, 4'b0000, 2'd1, 1'b1);
        step(1'b0, 1'b1, 4'h0, 4'b0010, 4'b0000, 2'd2, 1'b1);
        step(1'b0, 1'b1, 4'h0, 4'b0000, 4'b0001, 2'd2, 1'b1);
        step(1'b0, 1'b1, 4'h0, 4'b0000, 4'b0010, 2'd1, 1'b1);
        step(1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 2'd1, 1'b1);
        step(1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 2'd0, 1'b1);

        // reset right after a pop discards the in-flight word
        step(1'b0, 1'b1, 4'hE, 4'h0, 4'b0001, 2'd0, 1'b0);
        q.delete();
        step(1'b1, 1'b0, 4'hF, 4'h0, 4'b0000, 2'd1, 1'b0);
        check("post_reset_push", push, 4'b0);
        check("post_reset_data_out", data_out, 12'h0);
        step(1'b0, 1'b0, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0);
        step(1'b0, 1'b0, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0);
        step(1'b0, 1'b0, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0);
        check("scoreboard_drained", q.size(), 0);
`ifdef REFEREE_RR_DROP_CNT_EN
        check("main_drop_cnt", drop_cnt, 8'd0);
        check("main_drop_err", drop_err, 1'b0);
`endif

        // NUM_OUT=3: dest 3 is dropped, dest 2 is delivered
        din3 = {12'h000, 12'h000, 12'h8AB, 12'hC00};
        en3 = 1'b1; emp3 = 4'b1110;
        #2;
        check("d3_pop_src0", pop3, 4'b0001);
        @(posedge clk); #2;
        emp3 = 4'b1101;
        #2;
        check("d3_pop_src1", pop3, 4'b0010);
        check("d3_push_idle", push3, 3'b000);
        @(posedge clk); #2;
        en3 = 1'b0; emp3 = 4'hF;
        #2;
        check("d3_drop_push", push3, 3'b000);
        check("d3_drop_data_held", dout3, 12'h000);
        @(posedge clk); #2;
        #2;
        check("d3_push_dest2", push3, 3'b100);
        check("d3_data_dest2", dout3, 12'h8AB);
        @(posedge clk); #2;
        #2;
        check("d3_push_once", push3, 3'b000);
`ifdef REFEREE_RR_DROP_CNT_EN
        check("d3_drop_cnt", drop_cnt3, 8'd1);
        check("d3_drop_err", drop_err3, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/referee_rr.md
Name: referee_rr

Overview:
- Parametrised successor of the single-source referee stage in the transaction layer.
- Arbitrates round-robin among NUM_IN source FIFOs and pops at most one word per cycle.
- Routes each popped word to one of NUM_OUT destination FIFOs, selected by the word's top DEST_W bits.
- Adds an internal FSM, global almost-full back-pressure and a registered 2-cycle pop-to-push pipeline. It sits between the virtual-channel input FIFOs and the per-destination output FIFOs.

Parameters:
- LINE_SIZE, 12, word width in bits.
- NUM_IN, 4, number of source FIFOs (2..8).
- NUM_OUT, 4, number of destination FIFOs (1..8).
- DEST_W, 2, destination field width, taken from data bits [LINE_SIZE-1 -: DEST_W]. Must satisfy 2^DEST_W >= NUM_OUT. Ignored when NUM_OUT=1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  arbitration permitted when high.
- empty  in  NUM_IN  per-source FIFO empty flags.
- data_in  in  NUM_IN*LINE_SIZE  source FIFO read data, flattened (source i = bits [i*LINE_SIZE +: LINE_SIZE]); valid the cycle after pop[i].
- almost_full  in  NUM_OUT  per-destination almost-full flags.
- pop  out  NUM_IN  one-hot-or-zero read strobe to source FIFOs.
- push  out  NUM_OUT  one-hot-or-zero write strobe to destination FIFOs.
- data_out  out  LINE_SIZE  word presented with push.
- fsm_state  out  2  IDLE=0, ARB=1, STALL=2.

Behaviour:
Reset (synchronous, any cycle, including mid-transfer):
- pop=0, push=0, data_out=0, fsm_state=IDLE.
- Pipeline valid bits are cleared, so in-flight words are discarded.
- rr_ptr=NUM_IN-1, so the first grant goes to source 0.

FSM, evaluated every cycle:
- IDLE -> ARB when enable and |(~empty) and ~|almost_full.
- IDLE -> STALL when enable and |almost_full.
- ARB -> STALL when |almost_full.
- ARB -> IDLE when ~enable or &empty.
- STALL -> ARB when ~|almost_full and enable and |(~empty).
- STALL -> IDLE when ~|almost_full and (~enable or &empty).

Pop (combinational from the registered state and current inputs):
- pop is asserted only in a cycle where enable=1, ~|almost_full and at least one empty[i]=0. It is not gated by fsm_state, so a pop can occur in the same cycle the FSM leaves IDLE.
- Grant goes to the first non-empty source searching rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
- rr_ptr <= granted index, updated only on a grant.
- Never more than one pop bit set.

Pipeline:
- Stage 1: the pop cycle t registers sel_q=grant and v1=1.
- Stage 2: at the edge ending cycle t+1, data_out <= data_in slice sel_q, and push <= onehot(dest) when v1.
- push and data_out are therefore visible in cycle t+2, and push lasts exactly one cycle.
- data_out holds its last value while push=0.
- Sustained throughput is 1 word/cycle.

Back-pressure:
- almost_full only gates new pops.
- Up to 2 words already in flight are always pushed, even if almost_full rises. Destination FIFOs must assert almost_full with >= 2 free entries.

Destination decode:
- dest = data_in[sel_q*LINE_SIZE + LINE_SIZE-1 -: DEST_W]; dest=0 when NUM_OUT=1.
- If dest >= NUM_OUT, the word is dropped: no push, and data_out is not updated.

Enable:
- enable low blocks new pops only; in-flight words complete.

Optional Feature:
REFEREE_RR_DROP_CNT_EN:
- Defined: adds output port drop_cnt (8 bits) and sticky output drop_err (1 bit).
- drop_cnt increments on each dropped word, saturates at 255, and is cleared by reset.
- drop_err is set on the first drop and cleared only by reset.
- Undefined: the ports are absent; drops are silent.

Test Plan:
- Reset, then enable=1 with empty=4'b1111 -> pop=0, fsm_state=IDLE; after setting empty=4'b1110, pop=4'b0001 in that cycle and fsm_state=ARB next cycle.
- All 4 sources non-empty, no almost_full, 8 cycles -> pop sequence 0001,0010,0100,1000,0001,...; push begins 2 cycles after the first pop, one per cycle.
- Source 2 word 12'hA5C (dest=2'b10) -> push=4'b0100, data_out=12'hA5C exactly 2 cycles after pop=4'b0100.
- almost_full[1] asserted mid-stream -> pop=0 from that cycle, fsm_state=STALL next cycle, 2 in-flight words still pushed; on deassert, arbitration resumes at the next source after the last grant.
- NUM_OUT=3, word with dest=2'b11 -> no push. With REFEREE_RR_DROP_CNT_EN: drop_cnt=1, drop_err=1.
- Reset asserted the cycle after a pop -> no push appears and all outputs are 0 on the following cycle.
